// File: rtl/stopwatch_if.sv
// Stopwatch control/display bundle between the divider/buttons and the display path.
// The master drives tick and buttons; the slave (controller) drives digits and status.
interface stopwatch_if;
  logic       tick;
  logic       btn_ss;
  logic       btn_lap;
  logic       btn_clr;
  logic [3:0] sec_u;
  logic [3:0] sec_t;
  logic [3:0] min_u;
  logic [3:0] min_t;
  logic       running;
  logic       lap_active;
  logic       max_pulse;

  modport master (
    output tick, btn_ss, btn_lap, btn_clr,
    input  sec_u, sec_t, min_u, min_t, running, lap_active, max_pulse
  );

  modport slave (
    input  tick, btn_ss, btn_lap, btn_clr,
    output sec_u, sec_t, min_u, min_t, running, lap_active, max_pulse
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// BCD mm:ss stopwatch controller: IDLE/RUN/LAP/PAUSED FSM, tick prescaler and lap latch.
// All outputs are registered; the display shows the lap latch while in LAP.
module stopwatch_ctrl #(
  parameter bit          HOLD_AT_MAX   = 1'b0,
  parameter int unsigned TICKS_PER_SEC = 1
) (
  input logic        clk,
  input logic        reset,
  stopwatch_if.slave bus
);

  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PrescLast = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {StIdle, StRun, StLap, StPaused} state_e;

  state_e          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [15:0]     latch_q, latch_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            ss_prev_q, lap_prev_q, clr_prev_q;
  logic [15:0]     disp_q, disp_d;
  logic            running_q, running_d;
  logic            lap_act_q, lap_act_d;
  logic            max_q, max_d;

  logic [15:0]     cnt_inc;
  logic            at_max, qual;
  logic            clr_e, ss_e, lap_e;

  // One edge per cycle, clr > ss > lap.
  assign clr_e  = bus.btn_clr & ~clr_prev_q;
  assign ss_e   = bus.btn_ss & ~ss_prev_q & ~clr_e;
  assign lap_e  = bus.btn_lap & ~lap_prev_q & ~clr_e & ~ss_e;
  assign qual   = bus.tick & ((state_q == StRun) | (state_q == StLap));
  assign at_max = (cnt_q == 16'h5959);

  // cnt layout: {min_t, min_u, sec_t, sec_u}
  always_comb begin
    cnt_inc = cnt_q;
    if (cnt_q[3:0] != 4'd9) begin
      cnt_inc[3:0] = cnt_q[3:0] + 4'd1;
    end else begin
      cnt_inc[3:0] = 4'd0;
      if (cnt_q[7:4] != 4'd5) begin
        cnt_inc[7:4] = cnt_q[7:4] + 4'd1;
      end else begin
        cnt_inc[7:4] = 4'd0;
        if (cnt_q[11:8] != 4'd9) begin
          cnt_inc[11:8] = cnt_q[11:8] + 4'd1;
        end else begin
          cnt_inc[11:8] = 4'd0;
          if (cnt_q[15:12] != 4'd5) cnt_inc[15:12] = cnt_q[15:12] + 4'd1;
          else                      cnt_inc[15:12] = 4'd0;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch_d = latch_q;
    presc_d = presc_q;
    max_d   = 1'b0;
    if (clr_e) begin
      state_d = StIdle;
      cnt_d   = '0;
      latch_d = '0;
      presc_d = '0;
    end else begin
      if (qual) begin
        if (presc_q == PrescLast) begin
          presc_d = '0;
          if (at_max) begin
            max_d = 1'b1;
            cnt_d = HOLD_AT_MAX ? cnt_q : 16'h0000;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      unique case (state_q)
        StIdle:   if (ss_e) state_d = StRun;
        StRun: begin
          if (ss_e) begin
            state_d = StPaused;
          end else if (lap_e) begin
            state_d = StLap;
            latch_d = cnt_d;  // capture includes this cycle's increment
          end
        end
        StLap: begin
          if (ss_e)       state_d = StPaused;
          else if (lap_e) state_d = StRun;
        end
        StPaused: if (ss_e) state_d = StRun;
      endcase
      if (HOLD_AT_MAX && max_d) state_d = StPaused;
    end
    running_d = (state_d == StRun) || (state_d == StLap);
    lap_act_d = (state_d == StLap);
    disp_d    = (state_d == StLap) ? latch_d : cnt_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      latch_q    <= '0;
      presc_q    <= '0;
      // Held-high buttons across reset release must not look like a press.
      ss_prev_q  <= 1'b1;
      lap_prev_q <= 1'b1;
      clr_prev_q <= 1'b1;
      disp_q     <= '0;
      running_q  <= 1'b0;
      lap_act_q  <= 1'b0;
      max_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      latch_q    <= latch_d;
      presc_q    <= presc_d;
      ss_prev_q  <= bus.btn_ss;
      lap_prev_q <= bus.btn_lap;
      clr_prev_q <= bus.btn_clr;
      disp_q     <= disp_d;
      running_q  <= running_d;
      lap_act_q  <= lap_act_d;
      max_q      <= max_d;
    end
  end

  assign bus.sec_u      = disp_q[3:0];
  assign bus.sec_t      = disp_q[7:4];
  assign bus.min_u      = disp_q[11:8];
  assign bus.min_t      = disp_q[15:12];
  assign bus.running    = running_q;
  assign bus.lap_active = lap_act_q;
  assign bus.max_pulse  = max_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench: a vector table plus hand sequences for max count, pause and prescaler.
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Group A drives the TPS=1 pair (wrap and hold); group B drives the TPS=4 instance.
  logic a_tick = 0, a_ss = 0, a_lap = 0, a_clr = 0;
  logic b_tick = 0, b_ss = 0, b_lap = 0, b_clr = 0;

  stopwatch_if if0 ();
  stopwatch_if if1 ();
  stopwatch_if if2 ();

  assign if0.tick = a_tick;  assign if0.btn_ss = a_ss;
  assign if0.btn_lap = a_lap; assign if0.btn_clr = a_clr;
  assign if1.tick = a_tick;  assign if1.btn_ss = a_ss;
  assign if1.btn_lap = a_lap; assign if1.btn_clr = a_clr;
  assign if2.tick = b_tick;  assign if2.btn_ss = b_ss;
  assign if2.btn_lap = b_lap; assign if2.btn_clr = b_clr;

  stopwatch_ctrl #(.HOLD_AT_MAX(1'b0), .TICKS_PER_SEC(1)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  stopwatch_ctrl #(.HOLD_AT_MAX(1'b1), .TICKS_PER_SEC(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  stopwatch_ctrl #(.HOLD_AT_MAX(1'b0), .TICKS_PER_SEC(4)) dut2 (.clk(clk), .reset(reset), .bus(if2));

  // {min_t, min_u, sec_t, sec_u, running, lap_active, max_pulse}
  logic [18:0] obs0, obs1, obs2;
  assign obs0 = {if0.min_t, if0.min_u, if0.sec_t, if0.sec_u,
                 if0.running, if0.lap_active, if0.max_pulse};
  assign obs1 = {if1.min_t, if1.min_u, if1.sec_t, if1.sec_u,
                 if1.running, if1.lap_active, if1.max_pulse};
  assign obs2 = {if2.min_t, if2.min_u, if2.sec_t, if2.sec_u,
                 if2.running, if2.lap_active, if2.max_pulse};

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit          t, s, l, c;
    logic [18:0] exp;
  } vec_t;
  vec_t vecs[25];

  task automatic chk(input string name, input logic [18:0] got, input logic [18:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got mm:ss=%h run=%b lap=%b max=%b, want mm:ss=%h run=%b lap=%b max=%b",
               name, got[18:3], got[2], got[1], got[0], exp[18:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic cyc(input bit t, input bit s, input bit l, input bit c);
    a_tick = t; a_ss = s; a_lap = l; a_clr = c;
    @(posedge clk); #1;
  endtask

  task automatic cycb(input bit t, input bit s);
    b_tick = t; b_ss = s; b_lap = 0; b_clr = 0;
    @(posedge clk); #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{0, 0, 0, 0, {16'h0000, 3'b000}};
    vecs[1]  = '{0, 0, 1, 0, {16'h0000, 3'b000}};
    vecs[2]  = '{0, 0, 0, 0, {16'h0000, 3'b000}};
    vecs[3]  = '{1, 0, 0, 0, {16'h0000, 3'b000}};
    vecs[4]  = '{1, 1, 0, 0, {16'h0000, 3'b100}};
    vecs[5]  = '{1, 0, 0, 0, {16'h0001, 3'b100}};
    vecs[6]  = '{1, 0, 0, 0, {16'h0002, 3'b100}};
    vecs[7]  = '{1, 0, 0, 0, {16'h0003, 3'b100}};
    vecs[8]  = '{1, 0, 1, 0, {16'h0004, 3'b110}};
    vecs[9]  = '{1, 0, 0, 0, {16'h0004, 3'b110}};
    vecs[10] = '{1, 0, 0, 0, {16'h0004, 3'b110}};
    vecs[11] = '{0, 0, 1, 0, {16'h0006, 3'b100}};
    vecs[12] = '{1, 1, 0, 0, {16'h0007, 3'b000}};
    vecs[13] = '{1, 0, 0, 0, {16'h0007, 3'b000}};
    vecs[14] = '{0, 1, 0, 0, {16'h0007, 3'b100}};
    vecs[15] = '{0, 0, 1, 0, {16'h0007, 3'b110}};
    vecs[16] = '{1, 0, 0, 0, {16'h0007, 3'b110}};
    vecs[17] = '{1, 1, 0, 0, {16'h0009, 3'b000}};
    vecs[18] = '{0, 0, 1, 0, {16'h0009, 3'b000}};
    vecs[19] = '{0, 0, 0, 1, {16'h0000, 3'b000}};
    vecs[20] = '{0, 1, 0, 0, {16'h0000, 3'b100}};
    vecs[21] = '{1, 0, 0, 0, {16'h0001, 3'b100}};
    vecs[22] = '{1, 1, 0, 1, {16'h0000, 3'b000}};
    vecs[23] = '{0, 0, 0, 0, {16'h0000, 3'b000}};
    vecs[24] = '{0, 1, 0, 0, {16'h0000, 3'b100}};

    // Start/stop held through reset release must not start the watch.
    a_ss = 1;
    #2;
    do_reset();
    chk("rst_vals", obs0, {16'h0000, 3'b000});
    chk("rst_vals_tps4", obs2, {16'h0000, 3'b000});
    cyc(0, 1, 0, 0);
    chk("held_ss_no_edge", obs0, {16'h0000, 3'b000});
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    chk("ss_after_release", obs0, {16'h0000, 3'b100});

    a_ss = 0;
    do_reset();
    for (int i = 0; i < 25; i++) begin
      cyc(vecs[i].t, vecs[i].s, vecs[i].l, vecs[i].c);
      chk($sformatf("vec%0d", i), obs0, vecs[i].exp);
    end

    // 75 seconds.
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0); cyc(0, 0, 0, 0);
    ticks(75);
    chk("run_75s", obs0, {16'h0115, 3'b100});

    // Lap freezes display while live count continues.
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0); cyc(0, 0, 0, 0);
    ticks(10);
    cyc(0, 0, 1, 0);
    chk("lap_enter", obs0, {16'h0010, 3'b110});
    cyc(0, 0, 0, 0);
    ticks(5);
    chk("lap_frozen", obs0, {16'h0010, 3'b110});
    cyc(0, 0, 1, 0);
    chk("lap_exit", obs0, {16'h0015, 3'b100});

    // Roll over / saturate at 59:59.
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0); cyc(0, 0, 0, 0);
    ticks(3598);
    chk("pre_5958_wrap", obs0, {16'h5958, 3'b100});
    chk("pre_5958_hold", obs1, {16'h5958, 3'b100});
    ticks(1);
    chk("at_5959_wrap", obs0, {16'h5959, 3'b100});
    chk("at_5959_hold", obs1, {16'h5959, 3'b100});
    ticks(1);
    chk("max_wrap", obs0, {16'h0000, 3'b101});
    chk("max_hold", obs1, {16'h5959, 3'b001});
    cyc(0, 0, 0, 0);
    chk("max_pulse_end_wrap", obs0, {16'h0000, 3'b100});
    chk("max_pulse_end_hold", obs1, {16'h5959, 3'b000});
    ticks(1);
    chk("after_wrap", obs0, {16'h0001, 3'b100});
    chk("hold_paused", obs1, {16'h5959, 3'b000});

    // Asynchronous reset mid-run acts without waiting for a clock edge.
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset", obs0, {16'h0000, 3'b000});
    @(posedge clk); #1;
    reset = 1'b0;
    a_tick = 0;

    // TPS=4: partial second retained across pause.
    cycb(0, 0);
    cycb(0, 1);
    chk("tps4_start", obs2, {16'h0000, 3'b100});
    for (int i = 0; i < 6; i++) cycb(1, 0);
    chk("tps4_6ticks", obs2, {16'h0001, 3'b100});
    cycb(0, 1);
    chk("tps4_pause", obs2, {16'h0001, 3'b000});
    cycb(1, 0); cycb(1, 0);
    chk("tps4_paused_ticks", obs2, {16'h0001, 3'b000});
    cycb(0, 1);
    chk("tps4_resume", obs2, {16'h0001, 3'b100});
    cycb(1, 0);
    chk("tps4_tick7", obs2, {16'h0001, 3'b100});
    cycb(1, 0);
    chk("tps4_tick8", obs2, {16'h0002, 3'b100});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Stopwatch controller that sequences a BCD mm:ss time count from the 1 Hz enable produced by the upstream frequency divider.
- Accepts start/stop, lap and clear buttons and runs a four-state FSM: IDLE, RUN, LAP, PAUSED.
- Drives four BCD digits to the display path.
- Sits between the divider's tick output and the display mux/decoder.

Parameters:
- HOLD_AT_MAX, 0: 0 = count wraps 59:59 -> 00:00; 1 = count saturates at 59:59.
- TICKS_PER_SEC, 1: number of tick pulses per one-second increment, range 1..1000.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- tick  input  1  one-cycle enable from the divider (1 Hz).
- btn_ss  input  1  start/stop level, debounced and synchronous to clk.
- btn_lap  input  1  lap level, debounced and synchronous to clk.
- btn_clr  input  1  clear level, debounced and synchronous to clk.
- sec_u  output  4  displayed seconds units, BCD 0-9.
- sec_t  output  4  displayed seconds tens, BCD 0-5.
- min_u  output  4  displayed minutes units, BCD 0-9.
- min_t  output  4  displayed minutes tens, BCD 0-5.
- running  output  1  high in RUN or LAP.
- lap_active  output  1  high in LAP; display is frozen.
- max_pulse  output  1  one-cycle pulse when the count reaches 59:59 and a further increment occurs.

Behaviour:
Reset
- Asynchronous, active-high: state=IDLE; live count=00:00; lap latch=00:00; prescaler=0; max_pulse=0.
- Button history registers reset to 1, so a button held through reset release produces no edge.

Edge detection
- Each button press is a rising edge: level=1 and prev=0.
- Only one edge is acted on per cycle. Priority: clr > ss > lap.

FSM
- Transitions are registered and take effect on the next cycle.
- Any state, clr edge -> IDLE. Live count, prescaler and lap latch are zeroed on the same edge.
- IDLE, ss edge -> RUN.
- IDLE, lap edge -> ignored.
- RUN, ss edge -> PAUSED.
- RUN, lap edge -> LAP. The lap latch captures the live count as it stands after this cycle's tick (if any).
- LAP, lap edge -> RUN. Display returns to the live count.
- LAP, ss edge -> PAUSED. Display returns to the live count.
- PAUSED, ss edge -> RUN.
- PAUSED, lap edge -> ignored.

Counting
- Counting is qualified by the current registered state (RUN or LAP) and tick=1.
- A tick in the cycle of an ss edge that leaves RUN/LAP is counted.
- A tick in the cycle of an ss edge that enters RUN is not counted.
- Prescaler counts qualified ticks 0..TICKS_PER_SEC-1. The seconds increment fires when the prescaler is at TICKS_PER_SEC-1 with a qualified tick, and the prescaler returns to 0.
- The prescaler holds its value in PAUSED, so a partial second is retained across pause/resume.
- Increment cascade: sec_u 9->0 carries to sec_t; sec_t 5->0 carries to min_u; min_u 9->0 carries to min_t; min_t 5->0 is the full wrap.

At 59:59 with an increment
- HOLD_AT_MAX=0: count -> 00:00, max_pulse=1 for one cycle, state unchanged.
- HOLD_AT_MAX=1: count stays 59:59, max_pulse=1 for one cycle, state -> PAUSED.

Outputs
- All outputs are registered.
- Digits show the lap latch when state=LAP, otherwise the live count.
- Digits never leave their BCD ranges.

Reset mid-operation
- Reset asserted in any state forces the reset values immediately. No pending edge survives.

Test Plan:
- Reset release with btn_ss held high -> state IDLE, digits 00:00, no transition until btn_ss falls and rises again.
- ss edge, then 75 ticks (TICKS_PER_SEC=1) -> digits 01:15, running=1.
- ss edge, 10 ticks, lap edge, 5 ticks -> display 00:10, lap_active=1. Then lap edge -> display 00:15, lap_active=0.
- Preload to 59:58 via 3598 ticks, then 2 ticks -> HOLD_AT_MAX=0: 00:00 with max_pulse high exactly one cycle. HOLD_AT_MAX=1: 59:59, running=0.
- ss and clr edges in the same cycle while in RUN at 00:07 -> next cycle IDLE, 00:00. Tick coincident with ss edge from RUN -> counted.
- TICKS_PER_SEC=4: 6 ticks, ss edge (pause), 2 ticks, ss edge, 2 ticks -> 00:02. The prescaler is retained across the pause, and ticks in PAUSED are not counted.
